// File: rtl/alu_host_pkg.sv
// -----------------------------------------------------------------------------
// alu_host_pkg
// Shared definitions for the alu_host sequencing master: ALU op codes, the
// host FSM state encoding and a helper that tells whether an operation
// returns a two-byte result on the ALU outbus.
// Optional feature macro used by the host: ALU_HOST_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package alu_host_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_SEND_A  = 3'd2,
        ST_SEND_B  = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CAPT_LO = 3'd5,
        ST_RESP    = 3'd6
    } state_t;

    // MUL and DIV deliver a second byte on outbus the cycle after END.
    function automatic logic is_two_byte(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_host_wdog.sv
// -----------------------------------------------------------------------------
// alu_host_wdog
// Loadable, clearable down-counter with an expiry flag. Used by alu_host to
// bound the time spent waiting for the ALU's END strobe (only built when
// ALU_HOST_TIMEOUT_EN is defined).
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset (count -> 0)
//   clear     in   force the count to 0
//   load      in   load load_val (has priority over dec)
//   load_val  in   CNT_W-bit reload value
//   dec       in   decrement by one, saturating at 0
//   expired   out  count is 0
// -----------------------------------------------------------------------------
module alu_host_wdog #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/alu_host.sv
// -----------------------------------------------------------------------------
// alu_host
// Initiator for the ALU BEGIN/END operand-bus protocol. Accepts one request
// (op, a, b) over valid/ready, sequences BEGIN/op_code/inbus into the ALU,
// waits for END, assembles a one- or two-byte result from outbus and returns
// it as a 16-bit response over valid/ready. One transaction in flight.
//
// Optional feature: ALU_HOST_TIMEOUT_EN -- watchdog that aborts WAIT after
// TIMEOUT_CYCLES cycles without END, responding with rsp_err=1, rsp_data=0.
// Without it WAIT is unbounded and rsp_err is always 0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready request handshake; req_op/req_a/req_b request fields
//   rsp_valid/rsp_ready response handshake; rsp_data result, rsp_err abort
//   alu_begin, alu_op_code, alu_inbus   drive the ALU
//   alu_outbus, alu_end                 from the ALU
// All outputs are registered.
// -----------------------------------------------------------------------------
module alu_host
    import alu_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end
);

    state_t      state_q;
    state_t      state_d;

    logic [1:0]  op_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [7:0]  byte0_q;

    logic        timeout;

    logic        req_ready_d;
    logic        rsp_valid_d;
    logic [15:0] rsp_data_d;
    logic        rsp_err_d;
    logic        alu_begin_d;
    logic [1:0]  alu_op_code_d;
    logic [7:0]  alu_inbus_d;

`ifdef ALU_HOST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic wdog_expired;

    // Loaded with TIMEOUT_CYCLES-1 while entering WAIT, so expiry is seen in
    // the TIMEOUT_CYCLES-th WAIT cycle.
    alu_host_wdog #(
        .CNT_W (CNT_W)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_q == ST_RESP),
        .load     (state_q == ST_SEND_B),
        .load_val (CNT_W'(TIMEOUT_CYCLES - 1)),
        .dec      (state_q == ST_WAIT),
        .expired  (wdog_expired)
    );

    // END in the expiry cycle takes precedence over the abort.
    assign timeout = (state_q == ST_WAIT) && wdog_expired && !alu_end;
`else
    // WAIT is unbounded in this build; the parameter only keeps the
    // interface identical between builds.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // ---- state register -----------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields and first result byte carry no reset: they are only
    // consumed in states reached after being written.
    always_ff @(posedge clk) begin
        if ((state_q == ST_IDLE) && req_valid) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
        end
        if ((state_q == ST_WAIT) && alu_end) begin
            byte0_q <= alu_outbus;
        end
    end

    // ---- next-state logic ---------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req_valid) state_d = ST_START;
            ST_START:   state_d = ST_SEND_A;
            ST_SEND_A:  state_d = ST_SEND_B;
            ST_SEND_B:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (alu_end) begin
                    state_d = is_two_byte(op_q) ? ST_CAPT_LO : ST_RESP;
                end else if (timeout) begin
                    state_d = ST_RESP;
                end
            end
            ST_CAPT_LO: state_d = ST_RESP;
            ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ---- output logic (decoded from next state, then registered) ------------
    always_comb begin
        req_ready_d   = (state_d == ST_IDLE);
        rsp_valid_d   = (state_d == ST_RESP);
        alu_begin_d   = (state_d == ST_START) || (state_d == ST_SEND_A);
        alu_inbus_d   = 8'h00;
        alu_op_code_d = 2'b00;
        rsp_data_d    = rsp_data;
        rsp_err_d     = rsp_err;

        case (state_d)
            ST_SEND_A: alu_inbus_d = a_q;
            ST_SEND_B: alu_inbus_d = b_q;
            default:   alu_inbus_d = 8'h00;
        endcase

        // The op register is written on the same edge that enters START, so
        // the live request op is forwarded for that first cycle.
        case (state_d)
            ST_START, ST_SEND_A, ST_SEND_B, ST_WAIT, ST_CAPT_LO:
                alu_op_code_d = (state_q == ST_IDLE) ? req_op : op_q;
            default:
                alu_op_code_d = 2'b00;
        endcase

        // Result is latched only on entry to RESP and held there.
        if ((state_d == ST_RESP) && (state_q == ST_WAIT)) begin
            rsp_data_d = timeout ? 16'h0000 : {8'h00, alu_outbus};
            rsp_err_d  = timeout;
        end else if ((state_d == ST_RESP) && (state_q == ST_CAPT_LO)) begin
            rsp_data_d = {byte0_q, alu_outbus};
            rsp_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= 16'h0000;
            rsp_err     <= 1'b0;
            alu_begin   <= 1'b0;
            alu_op_code <= 2'b00;
            alu_inbus   <= 8'h00;
        end else begin
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_data    <= rsp_data_d;
            rsp_err     <= rsp_err_d;
            alu_begin   <= alu_begin_d;
            alu_op_code <= alu_op_code_d;
            alu_inbus   <= alu_inbus_d;
        end
    end

endmodule

// File: tb/tb_alu_host.sv
// -----------------------------------------------------------------------------
// tb_alu_host
// Self-checking bench for alu_host. The bench plays the ALU: it computes the
// arithmetic result from the operands and presents it on outbus at END.
// -----------------------------------------------------------------------------
module tb_alu_host;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [7:0]  req_a = 8'h00;
    logic [7:0]  req_b = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        alu_begin;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus = 8'h00;
    logic        alu_end = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_host #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .alu_begin   (alu_begin),
        .alu_op_code (alu_op_code),
        .alu_inbus   (alu_inbus),
        .alu_outbus  (alu_outbus),
        .alu_end     (alu_end)
    );

    // Packed response the host must return for an operation.
    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        case (op)
            2'b00:   return {8'h00, 8'((ai + bi) % 256)};
            2'b01:   return {8'h00, 8'((ai - bi + 256) % 256)};
            2'b10:   return 16'(ai * bi);
            default: return {8'(ai % bi), 8'(ai / bi)};
        endcase
    endfunction

    task automatic test_reset();
        logic [31:0] got, want;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        got  = 32'({req_ready, rsp_valid, rsp_data, rsp_err, alu_begin, alu_op_code, alu_inbus});
        want = 32'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 8'h00});
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", got, want);
        end
        reset = 1'b0;
    endtask

    // One full transaction; END arrives in the delay-th WAIT cycle and the
    // consumer withholds rsp_ready for hold cycles while a new request waits.
    task automatic run_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int delay, input int hold);
        logic [15:0] exp;
        logic [7:0]  b0, b1;
        logic [31:0] got, want;
        exp = ref_result(op, a, b);
        b0  = op[1] ? exp[15:8] : exp[7:0];
        b1  = exp[7:0];

        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle: got ready/valid %b expected 10", {req_ready, rsp_valid});
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        rsp_ready = 1'($urandom);

        // START, SEND_A, SEND_B: request fields and END are scrambled; both must be ignored.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 1'($urandom); req_op = 2'($urandom);
            req_a = 8'($urandom); req_b = 8'($urandom);
            alu_end = 1'($urandom); alu_outbus = 8'($urandom);
            got = 32'({req_ready, alu_begin, alu_inbus, alu_op_code, rsp_valid});
            if (c == 0)      want = 32'({1'b0, 1'b1, 8'h00, op, 1'b0});
            else if (c == 1) want = 32'({1'b0, 1'b1, a, op, 1'b0});
            else             want = 32'({1'b0, 1'b0, b, op, 1'b0});
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL send_seq%0d: got %h expected %h", c, got, want);
            end
        end
        req_valid = 1'b0;

        for (int k = 1; k <= delay; k++) begin
            @(negedge clk);
            alu_end    = (k == delay);
            alu_outbus = (k == delay) ? b0 : 8'($urandom);
            got  = 32'({req_ready, alu_begin, alu_inbus, alu_op_code, rsp_valid});
            want = 32'({1'b0, 1'b0, 8'h00, op, 1'b0});
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL wait%0d: got %h expected %h", k, got, want);
            end
        end

        @(negedge clk);
        alu_end = 1'($urandom);
        if (op[1]) begin
            alu_outbus = b1;
            got  = 32'({rsp_valid, alu_op_code, alu_begin, alu_inbus});
            want = 32'({1'b0, op, 1'b0, 8'h00});
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL capt_lo: got %h expected %h", got, want);
            end
            @(negedge clk);
            alu_end = 1'($urandom);
        end
        alu_outbus = 8'($urandom);
        rsp_ready  = (hold == 0);

        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(negedge clk);
                alu_end = 1'($urandom);
                rsp_ready = (h == hold);
            end
            if (h < hold) begin
                req_valid = 1'b1; req_op = 2'($urandom);
                req_a = 8'($urandom); req_b = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            got  = 32'({rsp_valid, rsp_data, rsp_err, req_ready, alu_op_code, alu_begin});
            want = 32'({1'b1, exp, 1'b0, 1'b0, 2'b00, 1'b0});
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL resp op=%0d a=%0d b=%0d hold%0d: got %h expected %h", op, a, b, h, got, want);
            end
        end
        alu_end = 1'b0;
    endtask

    task automatic test_directed();
        run_txn(2'b00, 8'd0,   8'd0, 4, 0);
        run_txn(2'b10, 8'd7,   8'd3, 2, 0);
        run_txn(2'b11, 8'd100, 8'd7, 3, 0);
        run_txn(2'b01, 8'd5,   8'd9, 1, 0);
    endtask

    task automatic test_back_to_back();
        run_txn(2'b01, 8'd200, 8'd55, 2, 5);
        run_txn(2'b10, 8'd255, 8'd255, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [7:0] b;
            op = 2'($urandom);
            b  = 8'($urandom);
            if (op == 2'b11 && b == 8'h00) b = 8'h01;
            run_txn(op, 8'($urandom), b, int'($urandom_range(1, TMO)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, want;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_a = 8'd9; req_b = 8'd9;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        got  = 32'({alu_begin, alu_inbus, req_ready, rsp_valid, alu_op_code});
        want = 32'({1'b0, 8'h00, 1'b1, 1'b0, 2'b00});
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected %h", got, want);
        end
        @(negedge clk);
        alu_end = 1'b1; alu_outbus = 8'hA5;
        @(negedge clk);
        alu_end = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if ({rsp_valid, req_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL reset_discard%0d: got valid/ready %b expected 01", c, {rsp_valid, req_ready});
            end
        end
    endtask

`ifdef ALU_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int at;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_a = 8'd12; req_b = 8'd12;
        @(negedge clk);
        req_valid = 1'b0;
        alu_end = 1'b0;
        repeat (2) @(negedge clk);
        at = 0;
        for (int k = 1; k <= TMO + 4 && at == 0; k++) begin
            @(negedge clk);
            if (rsp_valid) at = k;
        end
        n_checks++;
        if (at != TMO + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d expected %0d", at, TMO + 1);
        end
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL timeout_resp: got %h expected %h", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b1, 16'h0000});
        end
        rsp_ready = 1'b1;
    endtask
`else
    // Without the watchdog a very late END must still complete normally.
    task automatic test_long_wait();
        run_txn(2'b00, 8'd100, 8'd200, 3 * TMO, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef ALU_HOST_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        run_txn(2'b11, 8'd250, 8'd16, 2, 0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
